// File: rtl/vga_pattern_gen.sv
// Test-pattern generator downstream of the VGA timing controller.
// Two-stage pipeline: stage 1 registers coordinates and syncs, stage 2 registers colour and outputs.
module vga_pattern_gen #(
  parameter int unsigned H_START  = 144,
  parameter int unsigned V_START  = 35,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned BOX      = 32,
  parameter int unsigned STEP     = 4
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [31:0] hPixel,
  input  logic [31:0] line,
  input  logic        video_active,
  input  logic [1:0]  mode,
  input  logic [11:0] color_in,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hSync_out,
  output logic        vSync_out,
  output logic        active_out,
  output logic [7:0]  frame_count
);

  typedef enum logic {MOVE_POS, MOVE_NEG} dir_t;

  localparam logic [11:0] STEP_W = 12'(STEP);
  localparam logic [11:0] BOX_W  = 12'(BOX);
  localparam logic [11:0] H_W    = 12'(H_ACTIVE);
  localparam logic [11:0] V_W    = 12'(V_ACTIVE);
  localparam logic [10:0] BAR_W  = 11'(H_ACTIVE / 8);

  logic [10:0] x_s1, y_s1;
  logic        hs_s1, vs_s1, act_s1;
  logic [11:0] color_s1;

  logic [1:0]  mode_r;
  logic [10:0] box_x, box_y, box_x_next, box_y_next;
  dir_t        dir_x, dir_y, dir_x_next, dir_y_next;
  logic        frame_start;

  logic [10:0] bar;
  logic        in_box;
  logic [11:0] pattern, rgb;

  // Only the low 11 bits of the counters reach the coordinate arithmetic.
  logic unused_hi;
  assign unused_hi = ^{hPixel[31:11], line[31:11]};

  // vs_s1 doubles as the registered tap of the falling-edge detector.
  assign frame_start = vs_s1 & ~vSync;

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      x_s1     <= '0;
      y_s1     <= '0;
      hs_s1    <= 1'b1;
      vs_s1    <= 1'b1;
      act_s1   <= 1'b0;
      color_s1 <= '0;
    end else begin
      x_s1     <= hPixel[10:0] - 11'(H_START);
      y_s1     <= line[10:0] - 11'(V_START);
      hs_s1    <= hSync;
      vs_s1    <= vSync;
      act_s1   <= video_active;
      color_s1 <= color_in;
    end
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      box_x       <= '0;
      box_y       <= '0;
      dir_x       <= MOVE_POS;
      dir_y       <= MOVE_POS;
      mode_r      <= '0;
      frame_count <= '0;
    end else if (frame_start) begin
      box_x       <= box_x_next;
      box_y       <= box_y_next;
      dir_x       <= dir_x_next;
      dir_y       <= dir_y_next;
      mode_r      <= mode;
      frame_count <= frame_count + 8'd1;
    end
  end

  always_comb begin
    box_x_next = box_x;
    dir_x_next = dir_x;
    case (dir_x)
      MOVE_POS:
        if ({1'b0, box_x} + STEP_W + BOX_W >= H_W) begin
          box_x_next = 11'(H_ACTIVE - BOX);
          dir_x_next = MOVE_NEG;
        end else begin
          box_x_next = box_x + 11'(STEP);
        end
      MOVE_NEG:
        if ({1'b0, box_x} <= STEP_W) begin
          box_x_next = '0;
          dir_x_next = MOVE_POS;
        end else begin
          box_x_next = box_x - 11'(STEP);
        end
      default: ;
    endcase

    box_y_next = box_y;
    dir_y_next = dir_y;
    case (dir_y)
      MOVE_POS:
        if ({1'b0, box_y} + STEP_W + BOX_W >= V_W) begin
          box_y_next = 11'(V_ACTIVE - BOX);
          dir_y_next = MOVE_NEG;
        end else begin
          box_y_next = box_y + 11'(STEP);
        end
      MOVE_NEG:
        if ({1'b0, box_y} <= STEP_W) begin
          box_y_next = '0;
          dir_y_next = MOVE_POS;
        end else begin
          box_y_next = box_y - 11'(STEP);
        end
      default: ;
    endcase
  end

  always_comb begin
    bar    = x_s1 / BAR_W;
    in_box = ({1'b0, x_s1} >= {1'b0, box_x}) && ({1'b0, x_s1} < {1'b0, box_x} + BOX_W) &&
             ({1'b0, y_s1} >= {1'b0, box_y}) && ({1'b0, y_s1} < {1'b0, box_y} + BOX_W);
    pattern = '0;
    case (mode_r)
      2'd0:
        case (bar)
          11'd0:   pattern = 12'hFFF;
          11'd1:   pattern = 12'hFF0;
          11'd2:   pattern = 12'h0FF;
          11'd3:   pattern = 12'h0F0;
          11'd4:   pattern = 12'hF0F;
          11'd5:   pattern = 12'hF00;
          11'd6:   pattern = 12'h00F;
          default: pattern = 12'h000;
        endcase
      2'd1:    pattern = (x_s1[5] ^ y_s1[5]) ? 12'hFFF : 12'h000;
      2'd2:    pattern = in_box ? 12'hFFF : 12'h004;
      default: pattern = color_s1;
    endcase
    rgb = act_s1 ? pattern : '0;
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      hSync_out  <= 1'b1;
      vSync_out  <= 1'b1;
      active_out <= 1'b0;
    end else begin
      red        <= rgb[11:8];
      green      <= rgb[7:4];
      blue       <= rgb[3:0];
      hSync_out  <= hs_s1;
      vSync_out  <= vs_s1;
      active_out <= act_s1;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: directed and randomized pixels checked against a frame-level model.
module tb_vga_pattern_gen;

  logic        clock_in = 1'b0;
  logic        reset;
  logic        hSync, vSync, video_active;
  logic [31:0] hPixel, line;
  logic [1:0]  mode;
  logic [11:0] color_in;
  logic [3:0]  red, green, blue;
  logic        hSync_out, vSync_out, active_out;
  logic [7:0]  frame_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clock_in = ~clock_in;

  vga_pattern_gen #(
    .H_START(144), .V_START(35), .H_ACTIVE(640), .V_ACTIVE(480), .BOX(32), .STEP(4)
  ) dut (
    .clock_in(clock_in), .reset(reset), .hSync(hSync), .vSync(vSync),
    .hPixel(hPixel), .line(line), .video_active(video_active), .mode(mode),
    .color_in(color_in), .red(red), .green(green), .blue(blue),
    .hSync_out(hSync_out), .vSync_out(vSync_out), .active_out(active_out),
    .frame_count(frame_count)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        act;
  } exp_t;

  exp_t        pipe1;
  int unsigned frames_m;
  logic [1:0]  mode_m;
  logic        prev_vs;
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

  // Box position after n frames is a triangle wave over [0, span] with period 2*span/STEP.
  function automatic int unsigned bounce_pos(int unsigned n, int unsigned span);
    int unsigned p = 2 * span / 4;
    int unsigned m = n % p;
    return 4 * ((m < p - m) ? m : p - m);
  endfunction

  function automatic logic [11:0] pixel_color(int unsigned x, int unsigned y,
                                              logic [1:0] md, logic [11:0] solid);
    int unsigned bx = bounce_pos(frames_m, 608);
    int unsigned by = bounce_pos(frames_m, 448);
    case (md)
      2'd0:    return (x / 80 < 8) ? bars[x / 80] : 12'h000;
      2'd1:    return (((x / 32) + (y / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
      2'd2:    return (x >= bx && x < bx + 32 && y >= by && y < by + 32) ? 12'hFFF : 12'h004;
      default: return solid;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic hs, input logic vs, input int unsigned hp,
                      input int unsigned ln, input logic act);
    exp_t e;
    int unsigned x, y;
    hSync = hs; vSync = vs; hPixel = hp; line = ln; video_active = act;
    if (prev_vs && !vs) begin
      mode_m = mode;
      frames_m++;
    end
    prev_vs = vs;
    x = (hp - 144) & 32'h7FF;
    y = (ln - 35) & 32'h7FF;
    e.rgb = act ? pixel_color(x, y, mode_m, color_in) : 12'h000;
    e.hs  = hs;
    e.vs  = vs;
    e.act = act;
    @(posedge clock_in); #1;
    chk("rgb", {red, green, blue}, pipe1.rgb);
    chk("hsync", hSync_out, pipe1.hs);
    chk("vsync", vSync_out, pipe1.vs);
    chk("active", active_out, pipe1.act);
    chk("frame_count", frame_count, frames_m % 256);
    pipe1 = e;
  endtask

  task automatic pix(input int unsigned x, input int unsigned y);
    step(1'b1, 1'b1, x + 144, y + 35, 1'b1);
  endtask

  task automatic frame_start();
    step(1'b1, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b0, 10, 2, 1'b0);
    step(1'b1, 1'b0, 20, 2, 1'b0);
    step(1'b1, 1'b1, 30, 5, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_rgb", {red, green, blue}, 0);
    chk("rst_hsync", hSync_out, 1);
    chk("rst_vsync", vSync_out, 1);
    chk("rst_active", active_out, 0);
    chk("rst_frame_count", frame_count, 0);
    frames_m = 0;
    mode_m   = 2'd0;
    prev_vs  = 1'b1;
    pipe1    = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, act: 1'b0};
    hSync = 1'b1; vSync = 1'b1; hPixel = 0; line = 0; video_active = 1'b0;
    @(posedge clock_in); #1;
    @(posedge clock_in); #1;
    reset = 1'b1;
  endtask

  initial begin
    int unsigned bx, by, x, y;
    reset = 1'b1;
    mode = 2'd0; color_in = 12'h000;
    hSync = 1'b1; vSync = 1'b1; hPixel = 0; line = 0; video_active = 1'b0;
    #2;
    do_reset();

    // Idle after release, then an hSync pulse overlapping an active window.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 0, 0, 1'b0);
    for (int unsigned i = 0; i < 12; i++)
      step(!(i >= 3 && i < 6), 1'b1, 144 + i, 35, (i >= 5 && i < 10));

    // Colour bars: full sweep of line 35.
    mode = 2'd0;
    frame_start();
    for (int unsigned h = 144; h <= 783; h++) step(1'b1, 1'b1, h, 35, 1'b1);

    // Checkerboard corners plus random pixels.
    mode = 2'd1;
    frame_start();
    pix(0, 0); pix(32, 0); pix(32, 32); pix(0, 32); pix(63, 63); pix(64, 31);
    for (int i = 0; i < 10; i++) pix($urandom_range(0, 639), $urandom_range(0, 479));

    // Bouncing box over 160 frames from reset: edges probed every frame.
    do_reset();
    mode = 2'd2;
    for (int f = 0; f < 160; f++) begin
      frame_start();
      bx = bounce_pos(frames_m, 608);
      by = bounce_pos(frames_m, 448);
      pix(bx, by);
      pix(bx + 31, by + 31);
      if (bx + 32 < 640) pix(bx + 32, by);
      if (by + 32 < 480) pix(bx, by + 32);
      if (bx > 0) pix(bx - 1, by + 5);
      if (by > 0) pix(bx + 5, by - 1);
      pix($urandom_range(0, 639), $urandom_range(0, 479));
    end
    chk("frame_count_160", frame_count, 160);

    // Mode switch mid-frame takes effect only at the next frame start.
    mode = 2'd0;
    frame_start();
    mode = 2'd3; color_in = 12'hA5C;
    pix(0, 10); pix(100, 10); pix(600, 10);
    frame_start();
    pix(0, 0); pix(320, 240); pix(639, 479);

    // Randomized frames with random modes, colours, syncs and inactive samples.
    for (int f = 0; f < 40; f++) begin
      mode = 2'($urandom_range(0, 3));
      color_in = 12'($urandom);
      frame_start();
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) begin
          step(1'($urandom), 1'b1, $urandom_range(0, 2047), $urandom_range(0, 2047), 1'b0);
        end else begin
          x = $urandom_range(0, 639);
          y = $urandom_range(0, 479);
          step(1'($urandom), 1'b1, x + 144, y + 35, 1'b1);
        end
      end
    end

    // Mid-frame reset clears outputs immediately.
    mode = 2'd3; color_in = 12'hFFF;
    frame_start();
    pix(10, 10); pix(20, 10);
    do_reset();
    mode = 2'd1;
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 0, 0, 1'b0);
    frame_start();
    pix(32, 0); pix(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Downstream consumer of the video timing controller.
- Takes hSync, vSync, hPixel, line and video_active, and produces 4-bit-per-channel RGB for the VGA DAC pins.
- Selectable test patterns: colour bars, checkerboard, a bouncing box animated once per frame, and a solid colour.
- Sync and active outputs are delayed to stay cycle-aligned with the RGB pipeline.

Parameters:
- H_START, 144, first active hPixel value (pulse width plus back porch).
- V_START, 35, first active line value.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- BOX, 32, bouncing-box edge length in pixels.
- STEP, 4, box displacement per frame on each axis.

Ports:
- clock_in  input  1  pixel clock, same clock as the timing controller.
- reset  input  1  asynchronous active-low reset.
- hSync  input  1  horizontal sync from the timing controller, active low.
- vSync  input  1  vertical sync from the timing controller, active low.
- hPixel  input  32  horizontal pixel counter.
- line  input  32  vertical line counter.
- video_active  input  1  high during the visible region.
- mode  input  2  pattern select: 0 bars, 1 checker, 2 box, 3 solid.
- color_in  input  12  solid colour {R,G,B}, 4 bits each.
- red  output  4  red channel.
- green  output  4  green channel.
- blue  output  4  blue channel.
- hSync_out  output  1  hSync delayed 2 cycles.
- vSync_out  output  1  vSync delayed 2 cycles.
- active_out  output  1  video_active delayed 2 cycles.
- frame_count  output  8  frames started since reset, wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: red, green and blue = 0; hSync_out = 1; vSync_out = 1; active_out = 0; frame_count = 0.
  - Internal state: box_x = 0, box_y = 0, dx = dy = +1, mode_r = 0, all pipeline registers cleared (sync stages to 1).
- Two-stage pipeline; outputs are registered.
  - Stage 1 computes x = hPixel − H_START and y = line − V_START, keeping the low 11 bits. It registers x, y, hSync, vSync and video_active.
  - Stage 2 computes the colour and registers all outputs.
  - Latency is exactly 2 clocks from input to output for every signal.
- Frame-start event: vSync input is 1 on the previous clock and 0 on the current clock (falling-edge detector, one registered tap).
- On a frame-start event, in the same clock:
  - mode_r is loaded from mode. mode_r never changes mid-frame.
  - frame_count increments, wrapping 255→0.
  - The box update below executes.
- Box update (one FSM per axis, states MOVE_POS / MOVE_NEG, held in dx/dy):
  - MOVE_POS: if box_x + STEP + BOX ≥ H_ACTIVE, then box_x ← H_ACTIVE − BOX and the state becomes MOVE_NEG. Otherwise box_x ← box_x + STEP.
  - MOVE_NEG: if box_x ≤ STEP, then box_x ← 0 and the state becomes MOVE_POS. Otherwise box_x ← box_x − STEP.
  - The y axis is identical, using V_ACTIVE.
  - Box registers are 11 bits; the position is always in [0, ACTIVE − BOX].
- Colour, evaluated at stage 2 from stage-1 values:
  - Delayed active = 0: RGB = 0 for every mode.
  - Mode 0, colour bars: bar index = x / (H_ACTIVE/8), 0..7. Bars in order are white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - Mode 1, checkerboard: x[5] XOR y[5]; 1 → FFF, 0 → 000.
  - Mode 2, bouncing box: FFF when box_x ≤ x < box_x + BOX and box_y ≤ y < box_y + BOX; otherwise navy 004.
  - Mode 3, solid: color_in, sampled in stage 1.
- Simultaneous events: a mode change on the same clock as the frame-start event is taken, and the new mode applies to that frame.
- Reset asserted mid-frame clears everything immediately. After release, the first frame-start event loads mode and moves the box once.
- No combinational path from inputs to outputs.

Test Plan:
- Reset held, then released with vSync = 1 and idle inputs → red/green/blue = 0, hSync_out = vSync_out = 1, active_out = 0, frame_count = 0.
- hSync pulse and video_active toggle at cycle N → hSync_out and active_out show the identical waveform starting at cycle N+2; RGB is nonzero only while active_out = 1.
- Mode 0, line = 35, sweep hPixel 144..783 → colour changes every 80 pixels: hPixel 144 gives FFF, 224 gives FF0, 704 gives 000.
- Mode 1 → pixel (x=0, y=0) is 000, (32, 0) is FFF, (32, 32) is 000.
- Mode 2, run 160 frames:
  - box_x sequence 0, 4, …, 604, then 608 clamped; dx flips to MOVE_NEG at frame 152.
  - box_y reaches 448 at frame 112, then decrements.
  - frame_count reads 160.
- Mode switched 0→3 mid-frame with color_in = A5C → output stays bars until the next vSync falling edge, then the whole next frame is A5C. Reset pulsed mid-frame → outputs go to reset values within the same cycle.
